// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_WIDTH_DEFAULT = 8;

  // Iteration counter must be able to count up to the operand width.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/adder_rca.sv
// Ripple-carry adder used by the divider as a subtractor (b_i pre-inverted, cin_i=1).
module adder_rca #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  logic [WIDTH:0] carry;

  always_comb begin
    carry    = '0;
    carry[0] = cin_i;
    sum_o    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o = carry[WIDTH];

endmodule

// File: rtl/divider_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional DIV_BYZERO_EN: a zero divisor exits early with dbz set.
module divider_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz
);

  localparam int                CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [WIDTH:0]   a_q, a_d, m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d, quot_q, quot_d, rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic [2*WIDTH:0] pair_sh;
  logic [WIDTH:0]   a_sh, sum, a_nxt;
  logic [WIDTH-1:0] q_sh, q_nxt;
  logic             cout, accept, dz_exit;

  assign pair_sh = {a_q, q_q} << 1;
  assign a_sh    = pair_sh[2*WIDTH:WIDTH];
  assign q_sh    = pair_sh[WIDTH-1:0];

  adder_rca #(.WIDTH(WIDTH + 1)) u_addsub (
    .a_i    (a_sh),
    .b_i    (~m_q),
    .cin_i  (1'b1),
    .sum_o  (sum),
    .cout_o (cout)
  );

  // Carry-out set means the shifted remainder covers the divisor: keep the difference.
  assign a_nxt  = cout ? sum : a_sh;
  assign q_nxt  = q_sh | {{(WIDTH-1){1'b0}}, cout};
  assign accept = start && (state_q != CALC);

`ifdef DIV_BYZERO_EN
  assign dz_exit = (m_q == '0);
`else
  assign dz_exit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (dz_exit || (cnt_q == LAST)) state_d = DONE;
      DONE:    state_d = start ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CALC);
    done = (state_q == DONE);
  end

  always_comb begin
    a_d    = a_q;
    q_d    = q_q;
    m_d    = m_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    if (accept) begin
      a_d   = '0;
      q_d   = dividend;
      m_d   = {1'b0, divisor};
      cnt_d = '0;
      dbz_d = 1'b0;
    end else if (state_q == CALC) begin
      if (dz_exit) begin
        // Q still holds the unshifted dividend on the first CALC cycle.
        quot_d = '1;
        rem_d  = q_q;
        dbz_d  = 1'b1;
      end else begin
        a_d   = a_nxt;
        q_d   = q_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          quot_d = q_nxt;
          rem_d  = a_nxt[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      a_q    <= '0;
      q_q    <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      q_q    <= q_d;
      m_q    <= m_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq (WIDTH=8) with a queue-based scoreboard.
module tb_divider_seq;

`ifdef DIV_BYZERO_EN
  localparam bit BYZ = 1'b1;
`else
  localparam bit BYZ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_b = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy, done, dbz;
  logic [7:0] quotient, remainder;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         t0;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  divider_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [7:0] dd, input logic [7:0] dv, input int t0);
    exp_t e;
    e.q   = (dv == 8'd0) ? 8'hFF : dd / dv;
    e.r   = (dv == 8'd0) ? dd : dd % dv;
    e.z   = BYZ && (dv == 8'd0);
    e.t0  = t0;
    e.lat = (BYZ && (dv == 8'd0)) ? 2 : 9;
    return e;
  endfunction

  // Drives a one-cycle start; returns at the falling edge after it was sampled.
  task automatic issue(input logic [7:0] dd, input logic [7:0] dv);
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    sb.push_back(model(dd, dv, cyc));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_done(input string name);
    exp_t e;
    int   n = 0;
    while (done !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, done, n);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: done=1 with no result expected", name);
    end else begin
      e = sb.pop_front();
      checks++;
      if (quotient !== e.q) begin
        errors++;
        $display("FAIL %s quotient: got %0d required %0d", name, quotient, e.q);
      end
      checks++;
      if (remainder !== e.r) begin
        errors++;
        $display("FAIL %s remainder: got %0d required %0d", name, remainder, e.r);
      end
      checks++;
      if (dbz !== e.z) begin
        errors++;
        $display("FAIL %s dbz: got %b required %b", name, dbz, e.z);
      end
      checks++;
      if ((cyc - e.t0) != e.lat) begin
        errors++;
        $display("FAIL %s latency: got %0d required %0d", name, cyc - e.t0, e.lat);
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_b = 1'b0;
    #1;
    checks++;
    if ({busy, done, dbz, quotient, remainder} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b q=%0d r=%0d required all 0",
               busy, done, dbz, quotient, remainder);
    end
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_basic();
    int bcnt = 0;
    int n = 0;
    issue(8'd100, 8'd7);
    while (done !== 1'b1 && n < 30) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (bcnt != 8) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d required 8", bcnt);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_at_done: got %b required 0", busy);
    end
    check_done("basic_100_7");
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got %b required 0 one cycle later", done);
    end
  endtask

  task automatic test_corners();
    issue(8'd255, 8'd1);
    check_done("corner_255_1");
    issue(8'd5, 8'd9);
    check_done("corner_5_9");
    issue(8'd200, 8'd0);
    check_done("corner_200_0");
    issue(8'd0, 8'd13);
    check_done("corner_0_13");
    issue(8'd255, 8'd255);
    check_done("corner_255_255");
  endtask

  task automatic test_random();
    logic [7:0] dd, dv;
    for (int i = 0; i < 8; i++) begin
      dd = 8'($urandom_range(0, 255));
      dv = 8'($urandom_range(0, 255));
      if (i == 3) dv = 8'd0;
      issue(dd, dv);
      check_done("random");
    end
  endtask

  task automatic test_back_to_back();
    issue(8'd100, 8'd7);
    @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_done("b2b_first");
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    sb.push_back(model(8'd50, 8'd5, cyc));
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (quotient !== 8'd14 || remainder !== 8'd2) begin
      errors++;
      $display("FAIL b2b_hold: got q=%0d r=%0d required q=14 r=2", quotient, remainder);
    end
    check_done("b2b_second");
  endtask

  task automatic test_reset_abort();
    int dcnt = 0;
    issue(8'd100, 8'd7);
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    #1;
    checks++;
    if ({busy, done, dbz, quotient, remainder} !== 19'd0) begin
      errors++;
      $display("FAIL abort_outputs: got busy=%b done=%b dbz=%b q=%0d r=%0d required all 0",
               busy, done, dbz, quotient, remainder);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    checks++;
    if (dcnt != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses required 0", dcnt);
    end
    issue(8'd9, 8'd3);
    check_done("abort_then_9_3");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
